// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO write-side controller:
//   - fill_st_e : registered fill-state encoding (EMPTY/PART/AFULL/FULL)
//   - FILL_ST_W : width of the fill-state register
//   - fill_state(): maps an entry count onto a fill state
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FILL_ST_W = 2;

  typedef enum logic [FILL_ST_W-1:0] {
    ST_EMPTY = 2'd0,  // occ == 0
    ST_PART  = 2'd1,  // 0 < occ < AF_THR
    ST_AFULL = 2'd2,  // AF_THR <= occ < MEM_SIZE
    ST_FULL  = 2'd3   // occ == MEM_SIZE
  } fill_st_e;

  // Decode an entry count into its fill state.
  function automatic fill_st_e fill_state(input int occ, input int af_thr,
                                          input int mem_size);
    fill_st_e st;
    if (occ == 0)             st = ST_EMPTY;
    else if (occ >= mem_size) st = ST_FULL;
    else if (occ >= af_thr)   st = ST_AFULL;
    else                      st = ST_PART;
    return st;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Producer/controller handshake bundle for fifo_wr_ctrl.
//   master (producer side) drives : fifo_wr, pop, err_clr
//   slave  (controller) drives    : push, wr_ptr, occ, fifo_empty,
//                                   almost_full, fifo_full, wr_ovf
// Parameter PTR_L must match the PTR_L of the controller it connects to.
// -----------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
  parameter int PTR_L = 2
);

  logic             fifo_wr;      // write request from producer
  logic             pop;          // read side removes one entry this cycle
  logic             err_clr;      // clears sticky overflow flag
  logic             push;         // memory write enable this cycle
  logic [PTR_L-1:0] wr_ptr;       // memory address for the current push
  logic [PTR_L:0]   occ;          // entry count, 0..MEM_SIZE
  logic             fifo_empty;
  logic             almost_full;
  logic             fifo_full;
  logic             wr_ovf;       // sticky overflow error

  modport master (
    output fifo_wr, pop, err_clr,
    input  push, wr_ptr, occ, fifo_empty, almost_full, fifo_full, wr_ovf
  );

  modport slave (
    input  fifo_wr, pop, err_clr,
    output push, wr_ptr, occ, fifo_empty, almost_full, fifo_full, wr_ovf
  );

endinterface : fifo_wr_ctrl_if

// File: rtl/ptr_wrap_cnt.sv
// -----------------------------------------------------------------------------
// ptr_wrap_cnt
// Modulo-MEM_SIZE address counter. Works for any MEM_SIZE >= 2, not only
// powers of two, by wrapping explicitly at MEM_SIZE-1.
// Ports:
//   clk     : clock, rising edge
//   reset_L : asynchronous active-low reset, clears ptr to 0
//   inc     : advance the pointer by one this cycle
//   ptr     : current pointer value, 0..MEM_SIZE-1
// -----------------------------------------------------------------------------
module ptr_wrap_cnt #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             inc,
  output logic [PTR_L-1:0] ptr
);

  localparam logic [PTR_L-1:0] PTR_LAST = PTR_L'(MEM_SIZE - 1);

  logic [PTR_L-1:0] ptr_q, ptr_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block leaves a latch behind.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_L'(1);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule : ptr_wrap_cnt

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of a FIFO: produces the memory write enable and
// address, tracks occupancy against read-side pops, and reports fill status.
// Ports:
//   clk     : clock, rising edge
//   reset_L : asynchronous active-low reset
//   bus     : fifo_wr_ctrl_if.slave
//             in : fifo_wr, pop, err_clr
//             out: push, wr_ptr, occ, fifo_empty, almost_full, fifo_full,
//                  wr_ovf
// Parameters:
//   MEM_SIZE : number of entries (>= 2, any integer)
//   PTR_L    : pointer width, 2**PTR_L >= MEM_SIZE
//   AF_THR   : almost-full threshold in entries, 1..MEM_SIZE-1
// Configuration:
//   FIFO_WR_OVF_ERR_EN : when defined, wr_ovf is a sticky flag set by a
//                        write attempt while full and cleared by err_clr.
//                        When undefined, wr_ovf is tied 0 and err_clr is
//                        ignored.
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 2,
  parameter int AF_THR   = 3
) (
  input  logic           clk,
  input  logic           reset_L,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int OCC_W = PTR_L + 1;

  logic [OCC_W-1:0] occ_q, occ_d;
  fill_st_e         state_q, state_d;
  logic             push;
  logic             pop_eff;
  logic             full_flag;
  logic [PTR_L-1:0] wr_ptr;

  // ---------------------------------------------------------------------------
  // Write enable and address
  // ---------------------------------------------------------------------------
  assign full_flag = (state_q == ST_FULL);

  // Gating with reset_L keeps push low for the whole reset window, since a
  // combinational output cannot be cleared by the registers' async reset.
  // Using the registered full flag means a pop in a full cycle cannot make
  // room for a push in that same cycle.
  assign push = bus.fifo_wr & ~full_flag & reset_L;

  ptr_wrap_cnt #(
    .MEM_SIZE (MEM_SIZE),
    .PTR_L    (PTR_L)
  ) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .inc     (push),
    .ptr     (wr_ptr)
  );

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  // A pop against an empty FIFO is dropped so occ can never underflow.
  assign pop_eff = bus.pop & (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop_eff})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fill-state machine
  // ---------------------------------------------------------------------------
  // Decoding from occ_d (not occ_q) lets the flags move on the same edge as
  // the count. occ changes by at most one per edge, so the decoded state can
  // only step to an adjacent state.
  always_comb begin
    state_d = state_q;
    state_d = fill_state(int'(occ_d), AF_THR, MEM_SIZE);
  end

  // NOTE: only control/state flops live here and all of them get the async
  // reset; there is no storage array in this block that would need to be
  // left unreset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      occ_q   <= '0;
      state_q <= ST_EMPTY;
    end else begin
      occ_q   <= occ_d;
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow error
  // ---------------------------------------------------------------------------
`ifdef FIFO_WR_OVF_ERR_EN
  logic wr_ovf_q, wr_ovf_d;

  // A new overflow has priority over a clear request in the same cycle.
  always_comb begin
    wr_ovf_d = wr_ovf_q;
    if (bus.fifo_wr && full_flag) wr_ovf_d = 1'b1;
    else if (bus.err_clr)         wr_ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) wr_ovf_q <= 1'b0;
    else          wr_ovf_q <= wr_ovf_d;
  end

  assign bus.wr_ovf = wr_ovf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.wr_ovf     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.push        = push;
  assign bus.wr_ptr      = wr_ptr;
  assign bus.occ         = occ_q;
  assign bus.fifo_empty  = (state_q == ST_EMPTY);
  assign bus.almost_full = (state_q == ST_AFULL) || (state_q == ST_FULL);
  assign bus.fifo_full   = full_flag;

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Two controllers on one clock and reset: dut4 (MEM_SIZE=4, PTR_L=2,
// AF_THR=3) and dut5 (MEM_SIZE=5, PTR_L=3, AF_THR=4). The driver applies
// inputs on the falling edge and queues the outputs a counting model says
// the DUTs must show in that cycle; a monitor pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.PTR_L(2)) if4 ();
  fifo_wr_ctrl_if #(.PTR_L(3)) if5 ();

  fifo_wr_ctrl #(.MEM_SIZE(4), .PTR_L(2), .AF_THR(3)) dut4 (
    .clk     (clk),
    .reset_L (rst_n),
    .bus     (if4.slave)
  );

  fifo_wr_ctrl #(.MEM_SIZE(5), .PTR_L(3), .AF_THR(4)) dut5 (
    .clk     (clk),
    .reset_L (rst_n),
    .bus     (if5.slave)
  );

  typedef struct packed {
    logic       push;
    logic [2:0] ptr;
    logic [3:0] occ;
    logic       empty;
    logic       afull;
    logic       full;
    logic       ovf;
  } obs_t;

  typedef struct {
    obs_t e0;
    obs_t e1;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model: plain counts per DUT.
  int ms  [2] = '{4, 5};
  int thr [2] = '{3, 4};
  int m_occ [2] = '{0, 0};
  int m_ptr [2] = '{0, 0};
  int m_ovf [2] = '{0, 0};

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_occ[d] = 0;
      m_ptr[d] = 0;
      m_ovf[d] = 0;
    end
  endfunction

  // Returns this cycle's expected outputs and advances the model by one edge.
  function automatic obs_t model_step(int d, logic wr, logic pop, logic clr,
                                      logic rst);
    obs_t o;
    bit   full, do_push, do_pop;
    if (!rst) begin
      m_occ[d] = 0;
      m_ptr[d] = 0;
      m_ovf[d] = 0;
    end
    full    = (m_occ[d] == ms[d]);
    do_push = wr && !full && rst;
    do_pop  = pop && (m_occ[d] > 0);
    o.push  = do_push;
    o.ptr   = 3'(m_ptr[d]);
    o.occ   = 4'(m_occ[d]);
    o.empty = (m_occ[d] == 0);
    o.afull = (m_occ[d] >= thr[d]);
    o.full  = full;
    o.ovf   = (m_ovf[d] != 0);
    if (rst) begin
      if (do_push) m_ptr[d] = (m_ptr[d] + 1) % ms[d];
      m_occ[d] = m_occ[d] + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
`ifdef FIFO_WR_OVF_ERR_EN
      if (wr && full) m_ovf[d] = 1;
      else if (clr)   m_ovf[d] = 0;
`else
      if (clr) m_ovf[d] = 0;
`endif
    end
    return o;
  endfunction

  function automatic obs_t sample4();
    obs_t o;
    o.push  = if4.push;
    o.ptr   = {1'b0, if4.wr_ptr};
    o.occ   = {1'b0, if4.occ};
    o.empty = if4.fifo_empty;
    o.afull = if4.almost_full;
    o.full  = if4.fifo_full;
    o.ovf   = if4.wr_ovf;
    return o;
  endfunction

  function automatic obs_t sample5();
    obs_t o;
    o.push  = if5.push;
    o.ptr   = if5.wr_ptr;
    o.occ   = if5.occ;
    o.empty = if5.fifo_empty;
    o.afull = if5.almost_full;
    o.full  = if5.fifo_full;
    o.ovf   = if5.wr_ovf;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s @%0t: got push=%b ptr=%0d occ=%0d empty=%b afull=%b full=%b ovf=%b, expected push=%b ptr=%0d occ=%0d empty=%b afull=%b full=%b ovf=%b",
               name, $time, act.push, act.ptr, act.occ, act.empty, act.afull,
               act.full, act.ovf, exp.push, exp.ptr, exp.occ, exp.empty,
               exp.afull, exp.full, exp.ovf);
    end
  endtask

  // One clock cycle of stimulus for both DUTs.
  task automatic cyc(input logic rst, input logic w0, input logic p0,
                     input logic c0, input logic w1, input logic p1,
                     input logic c1);
    exp_t x;
    @(negedge clk);
    rst_n       = rst;
    if4.fifo_wr = w0;
    if4.pop     = p0;
    if4.err_clr = c0;
    if5.fifo_wr = w1;
    if5.pop     = p1;
    if5.err_clr = c1;
    x.e0 = model_step(0, w0, p0, c0, rst);
    x.e1 = model_step(1, w1, p1, c1, rst);
    exp_q.push_back(x);
  endtask

  task automatic cyc4(input logic w0, input logic p0, input logic c0);
    cyc(1'b1, w0, p0, c0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the queued expectation a little after the inputs move.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("dut4", sample4(), x.e0);
        check("dut5", sample5(), x.e1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rst_obs;
    int   wait_cnt;
    rst_obs = '{push: 1'b0, ptr: 3'd0, occ: 4'd0, empty: 1'b1,
                afull: 1'b0, full: 1'b0, ovf: 1'b0};
    if4.fifo_wr = 1'b0; if4.pop = 1'b0; if4.err_clr = 1'b0;
    if5.fifo_wr = 1'b0; if5.pop = 1'b0; if5.err_clr = 1'b0;

    // Reset held with a write request pending: push must stay low.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill dut4 with 5 write cycles; the fifth is refused (overflow).
    for (int i = 0; i < 5; i++) cyc4(1'b1, 1'b0, 1'b0);

    // Full: write + pop -> no push, occ drops to 3.
    cyc4(1'b1, 1'b1, 1'b0);

    // Pop to occ 2, then push+pop three times to put wr_ptr at 3, then once
    // more so the pointer wraps while occ stays 2.
    cyc4(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc4(1'b1, 1'b1, 1'b0);

    // Drain, then pop while empty for 3 cycles.
    for (int i = 0; i < 5; i++) cyc4(1'b0, 1'b1, 1'b0);

    // Overflow set, overflow+clear (set wins), plain clear, idle.
    for (int i = 0; i < 4; i++) cyc4(1'b1, 1'b0, 1'b0);
    cyc4(1'b1, 1'b0, 1'b0);
    cyc4(1'b1, 1'b0, 1'b1);
    cyc4(1'b0, 1'b0, 1'b1);
    cyc4(1'b0, 1'b0, 1'b0);

    // dut5: 7 pushes interleaved with pops; pointer wraps 4 -> 0.
    for (int i = 0; i < 14; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, (i % 2) == 0, (i % 2) == 1, 1'b0);

    // Randomized traffic: a write-heavy stretch then a pop-heavy stretch.
    for (int i = 0; i < 400; i++) begin
      logic w0, p0, c0, w1, p1, c1;
      int   pw;
      pw = (i < 200) ? 3 : 1;
      w0 = ($urandom_range(0, 3) < pw);
      p0 = ($urandom_range(0, 3) >= pw);
      c0 = ($urandom_range(0, 15) == 0);
      w1 = ($urandom_range(0, 3) < pw);
      p1 = ($urandom_range(0, 3) >= pw);
      c1 = ($urandom_range(0, 15) == 0);
      cyc(1'b1, w0, p0, c0, w1, p1, c1);
    end

    // Clean restart, then bring dut4 to occ 3 and reset asynchronously in
    // the middle of a cycle that is requesting a write.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dut4", sample4(), rst_obs);
    check("async_rst_dut5", sample5(), rst_obs);
    model_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Release: the first push happens on the first edge with reset high.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the queue, bounded.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    #5;
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 4, number of FIFO entries; any integer >= 2, not only powers of two.
REQ-002 The block SHALL have parameter PTR_L, default 2, write-pointer width; it SHALL satisfy 2**PTR_L >= MEM_SIZE.
REQ-003 The block SHALL have parameter AF_THR, default 3, almost-full threshold in entries; range 1..MEM_SIZE-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset_L, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port fifo_wr, input, 1 bit: write request from the producer.
REQ-007 The block SHALL have port pop, input, 1 bit: read-side removal of one entry this cycle.
REQ-008 The block SHALL have port err_clr, input, 1 bit: clears the sticky overflow flag.
REQ-009 The block SHALL have port push, output, 1 bit: memory write enable this cycle.
REQ-010 The block SHALL have port wr_ptr, output, PTR_L bits: memory address for the current push.
REQ-011 The block SHALL have port occ, output, PTR_L+1 bits: current entry count, 0..MEM_SIZE.
REQ-012 The block SHALL have ports fifo_empty, almost_full and fifo_full, each output, 1 bit: status flags.
REQ-013 The block SHALL have port wr_ovf, output, 1 bit: sticky overflow error.

Function
REQ-014 push SHALL equal fifo_wr AND NOT fifo_full AND reset_L, combinationally, with zero latency.
REQ-015 On a push, wr_ptr SHALL increment by 1; when a push occurs at wr_ptr = MEM_SIZE-1, wr_ptr SHALL wrap to 0.
REQ-016 occ SHALL update as follows: +1 on push without effective pop; -1 on effective pop without push; unchanged when both or neither occur.
REQ-017 A pop SHALL be effective only when occ > 0; a pop while empty SHALL be ignored, with no underflow.
REQ-018 With push and effective pop in the same cycle, occ SHALL be unchanged and wr_ptr SHALL still advance.
REQ-019 When full, fifo_wr together with pop SHALL NOT push, because push is gated by the registered fifo_full; occ SHALL decrement by 1.
REQ-020 A registered fill-state machine SHALL have four states: ST_EMPTY (occ=0), ST_PART (0<occ<AF_THR), ST_AFULL (AF_THR<=occ<MEM_SIZE), ST_FULL (occ=MEM_SIZE).
REQ-021 The next fill state SHALL be decoded from the next value of occ, so flags change in the same edge as occ.
REQ-022 Transitions SHALL occur only between adjacent states; one edge SHALL move at most one entry, so at most one state step per edge.
REQ-023 Flags SHALL decode from the state: fifo_empty = ST_EMPTY; almost_full = ST_AFULL or ST_FULL; fifo_full = ST_FULL.
REQ-024 wr_ovf SHALL set on the edge after any cycle in which fifo_wr=1 and fifo_full=1, and SHALL hold until cleared.
REQ-025 err_clr=1 SHALL clear wr_ovf on the next edge; a simultaneous new overflow event SHALL win and leave wr_ovf set.

Reset
REQ-026 Asserting reset_L low SHALL immediately set wr_ptr=0, occ=0, state=ST_EMPTY, wr_ovf=0 and push=0, independent of clk, including mid-operation.
REQ-027 After reset the outputs SHALL read fifo_empty=1, almost_full=0 and fifo_full=0.
REQ-028 On release, the first push SHALL occur on the first rising edge with reset_L high.

Configuration
REQ-029 The overflow-error feature SHALL be compiled in only when macro FIFO_WR_OVF_ERR_EN is defined.
REQ-030 With FIFO_WR_OVF_ERR_EN defined, REQ-024 and REQ-025 SHALL apply.
REQ-031 Without FIFO_WR_OVF_ERR_EN, wr_ovf SHALL be tied 0, err_clr SHALL be ignored and no overflow register SHALL exist.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the fill-state encodings (ST_EMPTY=0, ST_PART=1, ST_AFULL=2, ST_FULL=3) and the state width constant.
REQ-033 Sub-module ptr_wrap_cnt (parameters MEM_SIZE, PTR_L; inputs clk, reset_L, inc; output ptr) SHALL implement the modulo-MEM_SIZE pointer.
REQ-034 Occupancy, fill-state and error logic SHALL reside in fifo_wr_ctrl.

Verification
REQ-035 The bench SHALL cover this scenario (MEM_SIZE=4, AF_THR=3): reset, then fifo_wr=1 for 5 cycles, pop=0 -> 4 pushes at wr_ptr 0,1,2,3; occ 1,2,3,4; almost_full at occ=3; fifo_full at occ=4; 5th cycle push=0; wr_ovf=1 if enabled.
REQ-036 The bench SHALL cover this scenario: full, then fifo_wr=1 and pop=1 for 1 cycle -> push=0, occ 4->3, fifo_full=0, almost_full=1.
REQ-037 The bench SHALL cover this scenario: occ=2 with wr_ptr=3, then push+pop in the same cycle -> occ stays 2, wr_ptr wraps to 0.
REQ-038 The bench SHALL cover this scenario: empty, then pop=1 for 3 cycles -> occ stays 0, fifo_empty stays 1.
REQ-039 The bench SHALL cover this scenario: MEM_SIZE=5, PTR_L=3, 7 pushes interleaved with pops -> wr_ptr sequence 0,1,2,3,4,0,1 and never 5.
REQ-040 The bench SHALL cover this scenario: async reset_L low mid-cycle at occ=3 -> all outputs at reset values before the next clk edge; with wr_ovf=1, err_clr for 1 cycle -> wr_ovf=0.
